// File: rtl/exec_pipe_ctrl.sv
// exec_pipe_ctrl: PC / fetch-request owner, in-flight destination scoreboard,
// operand forward selects, load-use stall and branch-redirect flush for the
// RV32 execution unit. Operand data muxes live outside this block.

// One scoreboard stage: compares its tracked destination against both
// decode sources. A stage-1 load hit is what produces the load-use stall.
module exec_pipe_ctrl_stage (
    input  logic       vld,
    input  logic [4:0] rd,
    input  logic       ld,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    output logic       hit1,
    output logic       hit2,
    output logic       ld_hit
);
    // x0 is never a dependency, even if some stage claims to write it
    assign hit1   = vld & rs1_used & (rs1 != 5'd0) & (rd == rs1);
    assign hit2   = vld & rs2_used & (rs2 != 5'd0) & (rd == rs2);
    assign ld_hit = ld & (hit1 | hit2);
endmodule

module exec_pipe_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              FWD_DEPTH = 2,
    localparam int             SELW      = $clog2(FWD_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic            id_rs1_used,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            stall,
    output logic            flush,
    output logic [SELW-1:0] fwd_rs1_sel,
    output logic [SELW-1:0] fwd_rs2_sel
);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    sb_entry_t [FWD_DEPTH:1] sb_q;
    logic      [FWD_DEPTH:1] hit1, hit2, ld_hit;
    logic [XLEN-1:0]         pc_q;
    logic                    run_q;     // low until the first edge after reset release
    logic                    issue;
    logic                    unused_pc_lsb;

    // Redirect targets are word aligned; the low bits are dropped on purpose
    assign unused_pc_lsb = ^redirect_pc[1:0];

    generate
        for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_stage
            exec_pipe_ctrl_stage u_stage (
                .vld      (sb_q[k].vld),
                .rd       (sb_q[k].rd),
                .ld       (sb_q[k].ld),
                .rs1      (id_rs1),
                .rs1_used (id_rs1_used),
                .rs2      (id_rs2),
                .rs2_used (id_rs2_used),
                .hit1     (hit1[k]),
                .hit2     (hit2[k]),
                .ld_hit   (ld_hit[k])
            );
        end
    endgenerate

    // A load still in EX has no result yet; redirect kills the reader instead of holding it
    assign stall     = id_valid & ~redirect_en & ld_hit[1];
    assign flush     = run_q & redirect_en;
    assign imem_req  = run_q & ~stall;
    assign imem_addr = pc_q;
    assign issue     = id_valid & ~stall & ~flush;

    // Forward select: scan oldest to youngest so the youngest producer overrides
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (hit1[k]) fwd_rs1_sel = SELW'(k);
            if (hit2[k]) fwd_rs2_sel = SELW'(k);
        end
    end

    // Scoreboard: the back end never stalls, so entries advance every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q <= '0;
        end else begin
            sb_q[1].vld <= issue & id_rd_wen & (id_rd != 5'd0);
            sb_q[1].rd  <= issue ? id_rd : 5'd0;
            sb_q[1].ld  <= issue & id_is_load;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // PC: redirect, then stall hold, then advance on an accepted fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (imem_req && imem_gnt) begin
                pc_q <= pc_q + XLEN'(4);
            end
        end
    end

endmodule
